// File: rtl/filter_weight_loader.sv
// Filter weight loader: streams numWeight words into a slot bank and presents
// taps 0..3 plus the bias slot as registered outputs once a full set is held.
module filter_weight_loader #(
    parameter int unsigned numWeight    = 10,
    parameter int unsigned addressWidth = 4,
    parameter int unsigned dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic                    s_valid,
    input  logic [dataWidth-1:0]    s_data,
    output logic                    s_ready,
    input  logic                    en,
    output logic [dataWidth-1:0]    rdata0,
    output logic [dataWidth-1:0]    rdata1,
    output logic [dataWidth-1:0]    rdata2,
    output logic [dataWidth-1:0]    rdata3,
    output logic [dataWidth-1:0]    bias,
    output logic                    loaded,
    output logic [addressWidth-1:0] word_count
);

    localparam int unsigned LastSlot = numWeight - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOADED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [addressWidth-1:0] ptr_q, ptr_d;
    logic                    loaded_q, loaded_d;
    logic                    wr_en;
    logic [dataWidth-1:0]    slot_q [numWeight];
    logic [dataWidth-1:0]    rdata0_q, rdata1_q, rdata2_q, rdata3_q, bias_q;

    // State, pointer and loaded flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            loaded_q <= loaded_d;
        end
    end

    // Next-state logic; load_start always wins over a same-cycle transfer
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        loaded_d = loaded_q;
        wr_en    = 1'b0;
        case (state_q)
            IDLE, LOADED: begin
                if (load_start) begin
                    state_d  = LOAD;
                    ptr_d    = '0;
                    loaded_d = 1'b0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    ptr_d = '0;
                end else if (s_valid) begin
                    wr_en = 1'b1;
                    if (ptr_q == addressWidth'(LastSlot)) begin
                        state_d  = LOADED;
                        ptr_d    = '0;
                        loaded_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + addressWidth'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                ptr_d    = '0;
                loaded_d = 1'b0;
            end
        endcase
    end

    // Slot bank: one word written per accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(numWeight); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(numWeight); i++) begin
                if (wr_en && (ptr_q == addressWidth'(i))) begin
                    slot_q[i] <= s_data;
                end
            end
        end
    end

    // Output read registers, updated only on an enabled read of a complete set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            rdata3_q <= '0;
            bias_q   <= '0;
        end else if (en && (state_q == LOADED)) begin
            rdata0_q <= slot_q[0];
            rdata1_q <= slot_q[1];
            rdata2_q <= slot_q[2];
            rdata3_q <= slot_q[3];
            bias_q   <= slot_q[LastSlot];
        end
    end

    assign s_ready    = (state_q == LOAD);
    assign loaded     = loaded_q;
    assign word_count = ptr_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign rdata2     = rdata2_q;
    assign rdata3     = rdata3_q;
    assign bias       = bias_q;

endmodule

// File: doc/filter_weight_loader.md
FILTER_WEIGHT_LOADER -- requirements
Module: filter_weight_loader

Interface
REQ-001 Parameter numWeight, default 10, SHALL set the number of weight words held (filter taps plus bias in the last slot).
REQ-002 Parameter addressWidth, default 4, SHALL set the write-pointer width; it must satisfy 2^addressWidth >= numWeight.
REQ-003 Parameter dataWidth, default 16, SHALL set the weight word width.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 load_start  input  1  SHALL request a new weight load; it is a single-cycle pulse.
REQ-007 s_valid  input  1  SHALL mark s_data as a valid weight word.
REQ-008 s_data  input  dataWidth  SHALL carry the weight word, in slot order 0..numWeight-1.
REQ-009 s_ready  output  1  SHALL indicate the loader accepts a word this cycle.
REQ-010 en  input  1  SHALL be the read enable for the weight outputs.
REQ-011 rdata0..rdata3  output  dataWidth each  SHALL carry weight slots 0..3.
REQ-012 bias  output  dataWidth  SHALL carry slot numWeight-1.
REQ-013 loaded  output  1  SHALL be high while a complete weight set is held.
REQ-014 word_count  output  addressWidth  SHALL equal the current write pointer.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD and LOADED.
REQ-016 s_ready SHALL be 1 in LOAD only and 0 in IDLE and LOADED; it is decoded from the state register.
REQ-017 A transfer SHALL occur only on a cycle with s_valid=1 and s_ready=1.
REQ-018 In IDLE or LOADED, load_start=1 SHALL move to LOAD next cycle, clear the write pointer to 0 and clear loaded to 0.
REQ-019 Each transfer in LOAD SHALL write s_data into slot[word_count] and increment word_count by 1.
REQ-020 The transfer with word_count=numWeight-1 SHALL write the last slot and move to LOADED; the write pointer then returns to 0 and loaded=1 from the next cycle.
REQ-021 load_start=1 in LOAD SHALL restart the load: write pointer to 0, state stays LOAD, and any transfer in that same cycle is discarded (load_start has priority).
REQ-022 A load_start arriving on the same cycle as the final transfer SHALL take priority: the final word is discarded, the state stays LOAD and the pointer returns to 0.
REQ-023 s_valid in IDLE or LOADED SHALL be ignored; no slot write and no pointer change.
REQ-024 s_valid may be deasserted at any point mid-load; the pointer and slots SHALL hold until the next transfer (no timeout).
REQ-025 With en=1 in LOADED, rdata0..3 SHALL register slots 0..3 and bias SHALL register slot numWeight-1, with 1-cycle latency.
REQ-026 With en=0, or in any state other than LOADED, rdata0..3 and bias SHALL hold their previous values.
REQ-027 Slot contents SHALL persist across LOADED -> LOAD until each slot is overwritten.
REQ-028 No arithmetic is performed on the data; the pointer SHALL never exceed numWeight-1.

Reset
REQ-029 On rst_n=0 the block SHALL immediately (asynchronously) enter IDLE.
REQ-030 On rst_n=0 the following SHALL clear to 0: all slots, word_count, loaded, rdata0..3 and bias; s_ready follows to 0 through the IDLE decode.
REQ-031 Reset asserted mid-load SHALL abandon the load; after release the block stays in IDLE until load_start.
REQ-032 Reset release SHALL be synchronised externally; the block requires no first-cycle behaviour.

Verification
REQ-033 Basic load and read: reset, pulse load_start, stream 1..10 with s_valid held high.
- Required: s_ready high for exactly 10 transfer cycles; loaded=1 the cycle after the 10th word.
- Then pulse en: the next cycle shows rdata0..3=1,2,3,4 and bias=10.
REQ-034 Stalled load: same stream with s_valid low on alternate cycles.
- Required: word_count advances only on transfers; final outputs are identical to REQ-033.
REQ-035 Restart mid-load: send 5 words, pulse load_start with s_valid=1 and data 0xFFFF in the same cycle, then stream 0x0100..0x0109.
- Required: the 0xFFFF word is not written; word_count returns to 0.
- After en: rdata0=0x0100 and bias=0x0109.
REQ-036 Ignored traffic: in LOADED, drive s_valid=1 with 0xAAAA for 3 cycles.
- Required: s_ready=0 throughout; word_count=0; an en read returns the unchanged weights.
REQ-037 Reset mid-load: assert rst_n=0 after 4 words, then release.
- Required: immediately loaded=0, outputs=0 and state IDLE.
- en after release: outputs stay 0.
REQ-038 Reload: after a full load of 1..10, reload with 11..20.
- Required: loaded=0 during the reload and 1 after it.
- en read returns rdata0..3=11..14 and bias=20.
